fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the 8-bit program counter.
- Reads the current PC value and issues one read to the instruction memory. It pulses the PC enable so the counter advances exactly once per issued fetch.
- Returned instructions, tagged with their address, go into a 2-entry buffer that feeds the decoder through a valid/ready handshake.
- Branch redirect is out of scope, because the PC only supports reset and increment.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 72 +++++++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default widths, the fetch FSM state enum and the buffer entry type.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 16;
  localparam int FETCH_DEPTH   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fetch_state_e;

  // One buffered instruction, tagged with the address it was fetched from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  addr;
    logic [FETCH_INSTR_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO of fetched instructions.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the producer must reserve space before pushing.
// Ports: clk, reset (async, active-high); push/push_data write the tail; pop
//   retires the head; clear empties the FIFO (wins over push and pop);
//   count is the occupancy; head_valid/head_data present the oldest entry.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               clear,
  output logic [CNT_W-1:0]   count,
  output logic               head_valid,
  output fetch_entry_t       head_data
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop of an empty FIFO is ignored; clear overrides both directions.
  assign do_pop  = pop && (count != '0) && !clear;
  assign do_push = push && !clear;

  assign head_valid = (count != '0);
  assign head_data  = store[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The fetch FSM reserves a slot before issuing, so a full FIFO never sees a push.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count == FULL)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads pc_addr, issues one memory read, bumps the PC once per read.
// Latency: 2 cycles from the issue cycle to instr_valid with a 1-cycle memory; best rate 1 per 2 cycles.
// Backpressure: instr_ready low fills the 2-entry buffer, then issuing stops until a slot frees.
// Ports: clk, reset (async, active-high); run enables fetching; flush drops buffered and
//   in-flight instructions; pc_addr/pc_enable talk to the PC; mem_* is the instruction
//   memory read port; instr_valid/instr_data/instr_addr/instr_ready feed the decoder.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,   // must match the fetch_entry_t widths
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int DEPTH   = FETCH_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_enable,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_rvalid,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic               instr_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(DEPTH);

  fetch_state_e       state;
  logic               drop;      // the outstanding response belongs to a flushed fetch
  logic [ADDR_W-1:0]  req_addr;  // address of the read currently in flight

  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     count_x;
  logic [CNT_W:0]     count_after;
  logic               space_idle;
  logic               space_after;
  logic               resp;
  logic               push;
  logic               pop;
  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;

  // Responses only count while a read is actually outstanding; anything else is stray.
  assign resp = (state == WAIT) && mem_rvalid;
  assign push = resp && !drop && !flush;
  assign pop  = instr_valid && instr_ready;

  assign push_entry.addr = req_addr;
  assign push_entry.data = mem_rdata;

  // In IDLE nothing is outstanding, so space is just free buffer slots. Leaving WAIT the
  // read has landed, so space is judged on the occupancy after this cycle's push/pop.
  assign count_x     = {1'b0, count};
  assign count_after = count_x + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
  assign space_idle  = count_x < DEPTH_X;
  assign space_after = count_after < DEPTH_X;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drop      <= 1'b0;
      req_addr  <= '0;
      pc_enable <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      // Read strobe and PC bump are one-cycle pulses that only ever accompany ISSUE.
      pc_enable <= 1'b0;
      mem_rd    <= 1'b0;
      case (state)
        IDLE: begin
          if (run && space_idle && !flush) begin
            state     <= ISSUE;
            mem_rd    <= 1'b1;
            pc_enable <= 1'b1;
            mem_addr  <= pc_addr;
          end
        end
        ISSUE: begin
          // The PC only advances at the end of this cycle, so pc_addr is the issued address.
          req_addr <= pc_addr;
          if (flush) begin
            drop <= 1'b1;
          end
          state <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            drop <= 1'b0;
            if (run && space_after && !flush) begin
              state     <= ISSUE;
              mem_rd    <= 1'b1;
              pc_enable <= 1'b1;
              mem_addr  <= pc_addr;
            end else begin
              state <= IDLE;
            end
          end else if (flush) begin
            // The read cannot be cancelled; remember to discard its data when it lands.
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .clear      (flush),
    .count      (count),
    .head_valid (instr_valid),
    .head_data  (head_entry)
  );

  assign instr_addr = head_entry.addr;
  assign instr_data = head_entry.data;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        run;
  logic        flush;
  logic [7:0]  pc_addr;
  logic        pc_enable;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [7:0]  instr_addr;
  logic        instr_ready;

  int checks;
  int failures;
  int rd_cnt;
  int en_cnt;
  int lat;
  logic       q0_v, q1_v;
  logic [7:0] q0_a, q1_a;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .flush       (flush),
    .pc_addr     (pc_addr),
    .pc_enable   (pc_enable),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_addr  (instr_addr),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; advances one cycle. Models the PC
  // (increments after a pc_enable cycle) and a memory answering 16'hA000|addr
  // after lat cycles.
  task automatic step();
    logic       rd_now;
    logic       en_now;
    logic [7:0] a_now;
    rd_now = mem_rd;
    en_now = pc_enable;
    a_now  = mem_addr;
    if (rd_now) rd_cnt++;
    if (en_now) en_cnt++;
    @(posedge clk);
    #1;
    if (en_now) pc_addr = pc_addr + 8'd1;
    q1_v = q0_v;
    q1_a = q0_a;
    q0_v = rd_now;
    q0_a = a_now;
    if (lat == 1) begin
      mem_rvalid = q0_v;
      mem_rdata  = 16'hA000 | {8'h00, q0_a};
    end else begin
      mem_rvalid = q1_v;
      mem_rdata  = 16'hA000 | {8'h00, q1_a};
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic [7:0] pc0, input int l);
    reset       = 1'b1;
    run         = 1'b0;
    flush       = 1'b0;
    instr_ready = 1'b0;
    mem_rvalid  = 1'b0;
    q0_v = 1'b0; q1_v = 1'b0;
    step();
    step();
    reset   = 1'b0;
    pc_addr = pc0;
    lat     = l;
    rd_cnt  = 0;
    en_cnt  = 0;
  endtask

  initial begin
    checks = 0; failures = 0; rd_cnt = 0; en_cnt = 0; lat = 1;
    q0_v = 1'b0; q1_v = 1'b0; q0_a = 8'h00; q1_a = 8'h00;
    reset = 1'b1; run = 1'b0; flush = 1'b0; pc_addr = 8'h00;
    mem_rdata = 16'h0000; mem_rvalid = 1'b0; instr_ready = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_mem_rd",      mem_rd,      0);
    chk("rst_pc_enable",   pc_enable,   0);
    chk("rst_mem_addr",    mem_addr,    0);
    chk("rst_instr_data",  instr_data,  0);
    chk("rst_instr_addr",  instr_addr,  0);

    // Basic fetch: 00, 01, 02 issued on alternate cycles
    do_reset(8'h00, 1);
    run = 1'b1; instr_ready = 1'b1;
    step();
    chk("basic_c1_rd",   mem_rd,    1);
    chk("basic_c1_addr", mem_addr,  8'h00);
    chk("basic_c1_pce",  pc_enable, 1);
    step();
    chk("basic_c2_rd",   mem_rd,    0);
    step();
    chk("basic_c3_rd",   mem_rd,    1);
    chk("basic_c3_addr", mem_addr,  8'h01);
    chk("basic_c3_vld",  instr_valid, 1);
    chk("basic_c3_iadr", instr_addr,  8'h00);
    chk("basic_c3_idat", instr_data,  16'hA000);
    step();
    step();
    chk("basic_c5_addr", mem_addr,    8'h02);
    chk("basic_c5_iadr", instr_addr,  8'h01);
    chk("basic_c5_idat", instr_data,  16'hA001);
    run = 1'b0;
    step();
    chk("basic_c6_vld",  instr_valid, 0);
    step();
    chk("basic_c7_iadr", instr_addr,  8'h02);
    chk("basic_c7_idat", instr_data,  16'hA002);
    step();
    chk("basic_c8_vld",  instr_valid, 0);
    chk("basic_rd_cnt",  rd_cnt, 3);
    chk("basic_en_cnt",  en_cnt, 3);
    chk("basic_pc",      pc_addr, 8'h03);

    // Back-pressure: buffer fills with 00, 01, then issuing stops
    do_reset(8'h00, 1);
    run = 1'b1; instr_ready = 1'b0;
    steps(5);
    chk("bp_c5_rd",   mem_rd, 0);
    chk("bp_c5_iadr", instr_addr, 8'h00);
    steps(3);
    chk("bp_c8_rd",   mem_rd, 0);
    chk("bp_c8_pce",  pc_enable, 0);
    chk("bp_c8_pc",   pc_addr, 8'h02);
    chk("bp_rd_cnt",  rd_cnt, 2);
    instr_ready = 1'b1;
    step();
    chk("bp_c9_vld",  instr_valid, 1);
    chk("bp_c9_iadr", instr_addr, 8'h01);
    chk("bp_c9_rd",   mem_rd, 0);
    step();
    chk("bp_c10_rd",   mem_rd, 1);
    chk("bp_c10_addr", mem_addr, 8'h02);
    chk("bp_c10_vld",  instr_valid, 0);
    run = 1'b0;
    steps(2);
    chk("bp_c12_iadr", instr_addr, 8'h02);
    step();

    // Flush in WAIT, response arrives in the same cycle
    do_reset(8'h05, 1);
    run = 1'b1; instr_ready = 1'b1;
    step();
    chk("fl_c1_addr", mem_addr, 8'h05);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_c3_vld", instr_valid, 0);
    chk("fl_c3_rd",  mem_rd, 0);
    step();
    chk("fl_c4_rd",   mem_rd, 1);
    chk("fl_c4_addr", mem_addr, 8'h06);
    chk("fl_c4_vld",  instr_valid, 0);
    run = 1'b0;
    steps(2);
    chk("fl_c6_iadr", instr_addr, 8'h06);
    chk("fl_c6_idat", instr_data, 16'hA006);
    step();

    // Flush in WAIT before a latency-2 response: the late response must be dropped
    do_reset(8'h10, 2);
    run = 1'b1; instr_ready = 1'b1;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("drop_c3_vld", instr_valid, 0);
    step();
    chk("drop_c4_addr", mem_addr, 8'h11);
    chk("drop_c4_vld",  instr_valid, 0);
    run = 1'b0;
    steps(3);
    chk("drop_c7_vld",  instr_valid, 1);
    chk("drop_c7_iadr", instr_addr, 8'h11);
    chk("drop_c7_idat", instr_data, 16'hA011);
    step();

    // Simultaneous push of 04 and pop of 03
    do_reset(8'h03, 1);
    run = 1'b1; instr_ready = 1'b0;
    steps(3);
    chk("pp_c3_addr", mem_addr, 8'h04);
    chk("pp_c3_iadr", instr_addr, 8'h03);
    run = 1'b0;
    step();
    instr_ready = 1'b1;
    step();
    chk("pp_c5_vld",  instr_valid, 1);
    chk("pp_c5_iadr", instr_addr, 8'h04);
    chk("pp_c5_idat", instr_data, 16'hA004);
    instr_ready = 1'b0;
    step();
    chk("pp_c6_iadr", instr_addr, 8'h04);
    instr_ready = 1'b1;
    step();
    chk("pp_c7_vld",  instr_valid, 0);

    // Asynchronous reset while a read is outstanding
    do_reset(8'h20, 2);
    run = 1'b1; instr_ready = 1'b0;
    steps(4);
    run = 1'b0;
    step();
    chk("ar_pre_vld", instr_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_vld",  instr_valid, 0);
    chk("ar_rd",   mem_rd, 0);
    chk("ar_pce",  pc_enable, 0);
    chk("ar_iadr", instr_addr, 0);
    #2 reset = 1'b0;
    step();
    chk("ar_late_rvalid", mem_rvalid, 1);
    step();
    chk("ar_post_vld", instr_valid, 0);
    chk("ar_post_rd",  mem_rd, 0);

    // run dropped while waiting for 07
    do_reset(8'h07, 2);
    run = 1'b1; instr_ready = 1'b1;
    step();
    chk("rd_c1_addr", mem_addr, 8'h07);
    step();
    run = 1'b0;
    steps(2);
    chk("rd_c4_vld",  instr_valid, 1);
    chk("rd_c4_iadr", instr_addr, 8'h07);
    chk("rd_c4_idat", instr_data, 16'hA007);
    steps(4);
    chk("rd_rd_cnt",  rd_cnt, 1);
    chk("rd_end_vld", instr_valid, 0);

    // Address wrap FF -> 00
    do_reset(8'hFF, 1);
    run = 1'b1; instr_ready = 1'b1;
    steps(3);
    chk("wr_c3_addr", mem_addr, 8'h00);
    chk("wr_c3_iadr", instr_addr, 8'hFF);
    chk("wr_c3_idat", instr_data, 16'hA0FF);
    run = 1'b0;
    steps(2);
    chk("wr_c5_iadr", instr_addr, 8'h00);
    chk("wr_pulses",  en_cnt, rd_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
